mcycle_sequencer: RTL and testbench
===================================

# mcycle_sequencer

Control FSM that sequences the multi-cycle multiply/divide unit on behalf of the single-cycle ARM core. It sits between the decoder/condition logic and the MCycle unit. When a condition-passed MUL/DIV instruction is presented, it issues a one-cycle start to MCycle and stalls the program counter until the result is ready. It then writes the result back to the register file in a dedicated cycle.

## Interface
Parameters:
- WIDTH, 32, operand/result width.
- TIMEOUT, 63, maximum WAIT cycles before abort (used only with MCYCLE_TIMEOUT_EN).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- MulDivInstr  in  1  current instruction is MUL/DIV and its condition passed.
- OpIn  in  2  requested op: bit1=1 divide, bit0=1 signed.
- RdIn  in  4  destination register of the current instruction.
- Busy  in  1  MCycle is occupied.
- Done  in  1  MCycle one-cycle pulse; ResultIn valid in the same cycle.
- ResultIn  in  WIDTH  MCycle result.
- Start  out  1  registered one-cycle start pulse to MCycle.
- MCycleOp  out  2  registered op, held from START through WB.
- WE_PC  out  1  PC write enable; 0 = stall.
- RegWriteM  out  1  registered one-cycle register-file write enable.
- WA  out  4  write-back register address (latched RdIn).
- WD  out  WIDTH  write-back data (latched ResultIn).
- Fault  out  1  sticky timeout flag; tied to 0 without MCYCLE_TIMEOUT_EN.

## Operation
- States: IDLE, START, WAIT, WB, plus ABORT with the macro only.
- IDLE:
  - WE_PC = !MulDivInstr (combinational).
  - If MulDivInstr && !Busy: latch OpIn→MCycleOp and RdIn→WA, then go to START.
  - If MulDivInstr && Busy: stay in IDLE, stalled, with no Start.
- START:
  - Start=1 and WE_PC=0.
  - If Done: latch ResultIn→WD and go to WB. Otherwise go to WAIT.
- WAIT:
  - WE_PC=0.
  - On Done: latch ResultIn→WD and go to WB.
  - Done outside START/WAIT is ignored.
- WB:
  - RegWriteM=1 and WE_PC=1 (PC advances at the end of this cycle).
  - Unconditionally go to IDLE; MulDivInstr is ignored in WB.
- Back-to-back MUL/DIV: the next instruction is evaluated in the IDLE cycle after WB.
- Start, RegWriteM and Fault are registered. WE_PC is decoded from state plus MulDivInstr in IDLE.
- WD/WA hold their values until the next latch. Their only qualifier is RegWriteM.

## Timing
- Reset (asynchronous, any state):
  - State=IDLE.
  - Start=0, RegWriteM=0, MCycleOp=0, WA=0, WD=0, Fault=0.
  - WE_PC=1 while RESET is high.
- Reset mid-operation abandons the op with no write-back. MCycle is reset by the same RESET.
- Latency: define c0 = IDLE cycle where the op is accepted, and k = cycles from the Start cycle to Done (k≥0).
  - Start is high in c1.
  - WE_PC is low in c0 through c1+k.
  - RegWriteM and WE_PC are high in c2+k.
  - The instruction occupies k+3 cycles.
- Simultaneous Done and entry into WAIT is not possible, because Done in START is handled directly.

## Configuration
- MCYCLE_TIMEOUT_EN defined:
  - A cycle counter of width clog2(TIMEOUT+1) clears on entering WAIT and increments each WAIT cycle.
  - If the counter equals TIMEOUT with no Done, go to ABORT.
  - ABORT lasts one cycle: WE_PC=1, RegWriteM=0, Fault set sticky until RESET, then go to IDLE. The instruction is skipped.
  - Done arriving in the same cycle as the timeout wins: normal WB, no Fault.
- MCYCLE_TIMEOUT_EN undefined:
  - No counter and no ABORT state; WAIT waits indefinitely.
  - Fault is constant 0.

## Test plan
- Reset: assert RESET for 2 cycles mid-clock → Start=0, RegWriteM=0, WA=0, WD=0, Fault=0, WE_PC=1 immediately (asynchronous).
- MUL, OpIn=00, RdIn=4'd5, Done 4 cycles after Start with ResultIn=32'h0000_0051 → Start high in c1 only; WE_PC low in c0–c5; RegWriteM=1 in c6 with WA=5, WD=32'h51, MCycleOp=00.
- Busy=1 for 3 cycles while MulDivInstr=1 → no Start and WE_PC=0 for those cycles; Start appears the cycle after Busy falls.
- Done coincident with Start, ResultIn=32'hFFFF_FFFE, OpIn=11 → WAIT skipped; RegWriteM high in c2; total 3 cycles.
- RESET pulse during WAIT → IDLE immediately; no RegWriteM; a subsequent MUL completes normally.
- Macro on, TIMEOUT=8, Done never asserted → ABORT after 8 WAIT cycles; Fault=1 and stays 1; WE_PC=1 in ABORT; RegWriteM never asserts.

Source files
------------

// File: rtl/mcycle_sequencer.sv
// Sequencer that hands MUL/DIV instructions to the multi-cycle MCycle unit, stalls the PC, and writes back.
// Optional macro MCYCLE_TIMEOUT_EN adds a WAIT timeout that aborts the op into ABORT and sets a sticky Fault.
module mcycle_sequencer #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 63
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             MulDivInstr,
    input  logic [1:0]       OpIn,
    input  logic [3:0]       RdIn,
    input  logic             Busy,
    input  logic             Done,
    input  logic [WIDTH-1:0] ResultIn,
    output logic             Start,
    output logic [1:0]       MCycleOp,
    output logic             WE_PC,
    output logic             RegWriteM,
    output logic [3:0]       WA,
    output logic [WIDTH-1:0] WD,
    output logic             Fault
);

    // state | meaning
    // IDLE  | PC runs; accepts a MUL/DIV when MCycle is free
    // START | one-cycle Start pulse to MCycle, PC stalled
    // WAIT  | waiting for Done, PC stalled
    // WB    | register-file write of the result, PC advances
    // ABORT | timeout recovery: instruction skipped, Fault set
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_WB
`ifdef MCYCLE_TIMEOUT_EN
        , S_ABORT
`endif
    } state_t;

    state_t             state_q, state_d;
    logic               start_q, start_d;
    logic               regwrite_q, regwrite_d;
    logic [1:0]         op_q, op_d;
    logic [3:0]         wa_q, wa_d;
    logic [WIDTH-1:0]   wd_q, wd_d;
    logic               we_pc;

`ifdef MCYCLE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fault_q, fault_d;
    logic               timeout_hit;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        we_pc   = 1'b1;
        case (state_q)
            S_IDLE: begin
                we_pc = !MulDivInstr;
                if (MulDivInstr && !Busy) begin
                    op_d    = OpIn;
                    wa_d    = RdIn;
                    state_d = S_START;
                end
            end
            S_START: begin
                we_pc = 1'b0;
                // A zero-latency Done is taken here so WAIT never sees it.
                if (Done) begin
                    wd_d    = ResultIn;
                    state_d = S_WB;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                we_pc = 1'b0;
                if (Done) begin
                    wd_d    = ResultIn;
                    state_d = S_WB;
                end
`ifdef MCYCLE_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = S_ABORT;
                end
`endif
            end
            S_WB: begin
                state_d = S_IDLE;
            end
`ifdef MCYCLE_TIMEOUT_EN
            S_ABORT: begin
                state_d = S_IDLE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        start_d    = (state_d == S_START);
        regwrite_d = (state_d == S_WB);
    end

`ifdef MCYCLE_TIMEOUT_EN
    always_comb begin
        cnt_d   = cnt_q;
        fault_d = fault_q;
        if (state_q == S_START) begin
            cnt_d = '0;
        end else if (state_q == S_WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_d == S_ABORT) begin
            fault_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            regwrite_q <= 1'b0;
            op_q       <= '0;
            wa_q       <= '0;
            wd_q       <= '0;
`ifdef MCYCLE_TIMEOUT_EN
            cnt_q      <= '0;
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            regwrite_q <= regwrite_d;
            op_q       <= op_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
`ifdef MCYCLE_TIMEOUT_EN
            cnt_q      <= cnt_d;
            fault_q    <= fault_d;
`endif
        end
    end

    assign Start     = start_q;
    assign RegWriteM = regwrite_q;
    assign MCycleOp  = op_q;
    assign WA        = wa_q;
    assign WD        = wd_q;
    // The PC must keep running while held in reset even if MulDivInstr is high.
    assign WE_PC     = RESET | we_pc;

`ifdef MCYCLE_TIMEOUT_EN
    assign Fault = fault_q;
`else
    assign Fault = 1'b0;
    // TIMEOUT only shapes the abort path, which this build leaves out.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

endmodule

// File: tb/tb_mcycle_sequencer.sv
// Scoreboard bench for mcycle_sequencer: the driver queues expected Start and write-back events,
// a negedge monitor pops and compares them, and the driver checks the PC stall window inline.
module tb_mcycle_sequencer;

    logic        CLK;
    logic        RESET;
    logic        MulDivInstr;
    logic [1:0]  OpIn;
    logic [3:0]  RdIn;
    logic        Busy;
    logic        Done;
    logic [31:0] ResultIn;
    logic        Start;
    logic [1:0]  MCycleOp;
    logic        WE_PC;
    logic        RegWriteM;
    logic [3:0]  WA;
    logic [31:0] WD;
    logic        Fault;

    mcycle_sequencer #(.WIDTH(32), .TIMEOUT(8)) dut (
        .CLK(CLK), .RESET(RESET), .MulDivInstr(MulDivInstr), .OpIn(OpIn), .RdIn(RdIn),
        .Busy(Busy), .Done(Done), .ResultIn(ResultIn), .Start(Start), .MCycleOp(MCycleOp),
        .WE_PC(WE_PC), .RegWriteM(RegWriteM), .WA(WA), .WD(WD), .Fault(Fault)
    );

    typedef struct {
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [1:0]  op;
        int          cyc;
    } wb_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_q[$];
    wb_t  wb_q[$];
    wb_t  wb_e;
    int   start_e;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every Start / RegWriteM the DUT presents must match the head of its queue.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (Start === 1'b1) begin
                if (start_q.size() == 0) begin
                    chk("start_unexpected", 64'd1, 64'd0);
                end else begin
                    start_e = start_q.pop_front();
                    chk("start_cycle", 64'(cyc), 64'(start_e));
                end
            end
            if (RegWriteM === 1'b1) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", 64'd1, 64'd0);
                end else begin
                    wb_e = wb_q.pop_front();
                    chk("wb_cycle", 64'(cyc), 64'(wb_e.cyc));
                    chk("wb_wa", 64'(WA), 64'(wb_e.wa));
                    chk("wb_wd", 64'(WD), 64'(wb_e.wd));
                    chk("wb_op", 64'(MCycleOp), 64'(wb_e.op));
                end
            end
        end
    end

    task automatic chk_reset_values(input string tag);
        chk({tag, "_start"}, 64'(Start), 64'd0);
        chk({tag, "_regwrite"}, 64'(RegWriteM), 64'd0);
        chk({tag, "_op"}, 64'(MCycleOp), 64'd0);
        chk({tag, "_wa"}, 64'(WA), 64'd0);
        chk({tag, "_wd"}, 64'(WD), 64'd0);
        chk({tag, "_fault"}, 64'(Fault), 64'd0);
        chk({tag, "_we_pc"}, 64'(WE_PC), 64'd1);
    endtask

    // Called just after a posedge in an IDLE cycle (c0). Returns just after the posedge of c3+k.
    task automatic run_op(input logic [1:0] op, input logic [3:0] rd, input int k, input logic [31:0] res);
        int  c0;
        wb_t e;
        c0 = cyc;
        MulDivInstr = 1'b1;
        OpIn = op;
        RdIn = rd;
        Busy = 1'b0;
        Done = 1'b0;
        ResultIn = $urandom;
        start_q.push_back(c0 + 1);
        e.wa = rd; e.wd = res; e.op = op; e.cyc = c0 + 2 + k;
        wb_q.push_back(e);
        @(negedge CLK);
        chk("stall_c0", 64'(WE_PC), 64'd0);
        for (int i = 0; i <= k; i++) begin
            @(posedge CLK); #1;
            OpIn = 2'($urandom);
            RdIn = 4'($urandom);
            Done = (i == k);
            ResultIn = (i == k) ? res : $urandom;
            @(negedge CLK);
            chk("stall_busy", 64'(WE_PC), 64'd0);
        end
        @(posedge CLK); #1;
        Done = 1'b0;
        ResultIn = $urandom;
        @(negedge CLK);
        chk("wb_we_pc", 64'(WE_PC), 64'd1);
        @(posedge CLK); #1;
        MulDivInstr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        RESET = 1'b0;
        MulDivInstr = 1'b0;
        OpIn = 2'b00;
        RdIn = 4'd0;
        Busy = 1'b0;
        Done = 1'b0;
        ResultIn = 32'd0;

        #3;
        RESET = 1'b1;
        MulDivInstr = 1'b1;
        #1;
        chk_reset_values("reset");
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        MulDivInstr = 1'b0;
        @(posedge CLK); #1;

        run_op(2'b00, 4'd5, 4, 32'h0000_0051);

        MulDivInstr = 1'b1;
        OpIn = 2'b01;
        RdIn = 4'd9;
        Busy = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("busy_stall", 64'(WE_PC), 64'd0);
            chk("busy_no_start", 64'(Start), 64'd0);
            @(posedge CLK); #1;
        end
        run_op(2'b01, 4'd9, 2, 32'hDEAD_BEEF);

        run_op(2'b11, 4'd14, 0, 32'hFFFF_FFFE);

        run_op(2'b10, 4'd3, 1, 32'h0000_0007);
        run_op(2'b01, 4'd15, 3, 32'h8000_0001);

        Done = 1'b1;
        ResultIn = 32'h5555_AAAA;
        @(negedge CLK);
        chk("idle_done_we_pc", 64'(WE_PC), 64'd1);
        @(posedge CLK); #1;
        Done = 1'b0;
        @(negedge CLK);
        chk("idle_done_wd_hold", 64'(WD), 64'h8000_0001);
        chk("idle_done_wa_hold", 64'(WA), 64'd15);
        @(posedge CLK); #1;

        c0 = cyc;
        MulDivInstr = 1'b1;
        OpIn = 2'b10;
        RdIn = 4'd7;
        start_q.push_back(c0 + 1);
        repeat (3) begin
            @(posedge CLK); #1;
        end
        #2;
        RESET = 1'b1;
        #1;
        chk_reset_values("reset_wait");
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        MulDivInstr = 1'b0;
        @(posedge CLK); #1;
        run_op(2'b00, 4'd1, 2, 32'h0000_1234);

`ifdef MCYCLE_TIMEOUT_EN
        c0 = cyc;
        MulDivInstr = 1'b1;
        OpIn = 2'b00;
        RdIn = 4'd2;
        start_q.push_back(c0 + 1);
        @(negedge CLK);
        chk("to_stall_c0", 64'(WE_PC), 64'd0);
        for (int i = 1; i <= 9; i++) begin
            @(posedge CLK); #1;
            @(negedge CLK);
            chk("to_stall", 64'(WE_PC), 64'd0);
            chk("to_fault_low", 64'(Fault), 64'd0);
        end
        @(posedge CLK); #1;
        MulDivInstr = 1'b0;
        @(negedge CLK);
        chk("abort_we_pc", 64'(WE_PC), 64'd1);
        chk("abort_fault", 64'(Fault), 64'd1);
        repeat (3) begin
            @(posedge CLK); #1;
            @(negedge CLK);
            chk("fault_sticky", 64'(Fault), 64'd1);
        end
`endif

        repeat (4) @(posedge CLK);
        #1;
        chk("start_q_empty", 64'(start_q.size()), 64'd0);
        chk("wb_q_empty", 64'(wb_q.size()), 64'd0);
`ifdef MCYCLE_TIMEOUT_EN
        chk("final_fault", 64'(Fault), 64'd1);
`else
        chk("final_fault", 64'(Fault), 64'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
